// File: rtl/led_scan_multi.sv
// ---------------------------------------------------------------------------------------------
// led_scan_multi
//
// Multiplexed 7-segment scanner for DIGITS common-anode digits on one shared segment bus.
// Each digit owns a slot of SCAN_DIV clocks. The first BLANK_CYC clocks of a slot keep all
// anodes off so the previous digit cannot ghost. After that, the digit is lit for a
// brightness-dependent window. Inputs are sampled once per frame, so the display never
// shows a half-updated value.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   digits      hex code per digit, digit k = digits[4k+3:4k]
//   point       decimal point per digit, 1 = lit
//   blink_mask  1 = digit blinks with the shared blink phase
//   blank_mask  1 = digit forced dark
//   brightness  duty level, 0 = dimmest lit, 15 = full
//   ledCode     segments, active low, [7] = dp, [6:0] = gfedcba
//   an          anode selects, active low, at most one bit low
//   scan_idx    digit currently in its slot
//   frame_done  one-cycle pulse at the end of the last digit slot
// ---------------------------------------------------------------------------------------------
module led_scan_multi #(
   parameter int unsigned DIGITS       = 8,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYC    = 500,
   parameter int unsigned BLINK_FRAMES = 128,
   parameter int unsigned IDX_W        = $clog2(DIGITS)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [4*DIGITS-1:0]   digits,
   input  logic [DIGITS-1:0]     point,
   input  logic [DIGITS-1:0]     blink_mask,
   input  logic [DIGITS-1:0]     blank_mask,
   input  logic [3:0]            brightness,
   output logic [7:0]            ledCode,
   output logic [DIGITS-1:0]     an,
   output logic [IDX_W-1:0]      scan_idx,
   output logic                  frame_done
);

   localparam int unsigned CNT_W   = $clog2(SCAN_DIV + 1);
   localparam int unsigned FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int unsigned ACT_CYC = SCAN_DIV - BLANK_CYC;
   // End of the lit window for brightness 0; the reset value of the window register.
   localparam int unsigned ON_END_RST = BLANK_CYC + (ACT_CYC >> 4);

   // Slot / scan state
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                wrap_slot, wrap_frame;

   // Blink state
   logic [FRM_W-1:0]    frm_q;
   logic                phase_q;

   // Frame shadows. Brightness is kept only as the precomputed end of the lit window.
   logic                cap_q;
   logic [4*DIGITS-1:0] digits_sh_q;
   logic [DIGITS-1:0]   point_sh_q;
   logic [DIGITS-1:0]   blink_sh_q;
   logic [DIGITS-1:0]   blank_sh_q;
   logic [CNT_W-1:0]    on_end_q, on_end_d;

   // Output next-state
   logic [3:0]          cur_digit;
   logic                in_win, suppress, lit;
   logic [7:0]          led_d;
   logic [DIGITS-1:0]   an_d;

   function automatic logic [6:0] glyph(input logic [3:0] h);
      logic [6:0] g;
      unique case (h)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         4'hF: g = 7'h0E;
      endcase
      return g;
   endfunction

   always_comb begin
      wrap_slot  = (cnt_q == CNT_W'(SCAN_DIV - 1));
      wrap_frame = wrap_slot && (idx_q == IDX_W'(DIGITS - 1));

      cnt_d = wrap_slot ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (wrap_slot) begin
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end

      // The multiply is by a constant and is only registered at frame capture, so it is
      // not part of the per-cycle compare path.
      on_end_d = CNT_W'(BLANK_CYC + ((ACT_CYC * (32'(brightness) + 32'd1)) >> 4));
   end

   always_comb begin
      cur_digit = digits_sh_q[4*idx_q +: 4];
      in_win    = (cnt_q >= CNT_W'(BLANK_CYC)) && (cnt_q < on_end_q);
      suppress  = blank_sh_q[idx_q] | (blink_sh_q[idx_q] & phase_q);
      lit       = in_win & ~suppress;

      an_d  = '1;
      led_d = 8'hFF;
      if (lit) begin
         an_d[idx_q] = 1'b0;
         led_d       = {~point_sh_q[idx_q], glyph(cur_digit)};
      end
   end

   // Scan counters and blink phase
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         frm_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         if (wrap_frame) begin
            if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
               frm_q   <= '0;
               phase_q <= ~phase_q;
            end else begin
               frm_q <= frm_q + 1'b1;
            end
         end
      end
   end

   // Frame-coherent capture: armed by reset and by the end of every frame, taken one
   // cycle later (inside the blanking interval of digit 0).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_q       <= 1'b1;
         digits_sh_q <= '0;
         point_sh_q  <= '0;
         blink_sh_q  <= '0;
         blank_sh_q  <= '0;
         on_end_q    <= CNT_W'(ON_END_RST);
      end else begin
         cap_q <= wrap_frame;
         if (cap_q) begin
            digits_sh_q <= digits;
            point_sh_q  <= point;
            blink_sh_q  <= blink_mask;
            blank_sh_q  <= blank_mask;
            on_end_q    <= on_end_d;
         end
      end
   end

   // Registered outputs; an and ledCode always update on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         an         <= '1;
         ledCode    <= 8'hFF;
         scan_idx   <= '0;
         frame_done <= 1'b0;
      end else begin
         an         <= an_d;
         ledCode    <= led_d;
         scan_idx   <= idx_q;
         frame_done <= wrap_frame;
      end
   end

endmodule

// File: tb/tb_led_scan_multi.sv
// ---------------------------------------------------------------------------------------------
// tb_led_scan_multi
//
// Bench for led_scan_multi with DIGITS=4, SCAN_DIV=40, BLANK_CYC=4, BLINK_FRAMES=2.
// Expected outputs come from a reference model that works from the cycle count since
// reset release: slot position, digit, frame and blink phase by division, and inputs
// snapshotted per frame.
// ---------------------------------------------------------------------------------------------
module tb_led_scan_multi;

   localparam int D  = 4;
   localparam int SD = 40;
   localparam int BC = 4;
   localparam int BF = 2;
   localparam int FR = SD * D;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] digits;
   logic [3:0]  point, blink_mask, blank_mask, brightness;
   logic [7:0]  ledCode;
   logic [3:0]  an;
   logic [1:0]  scan_idx;
   logic        frame_done;

   always #5 clk = ~clk;

   led_scan_multi #(
      .DIGITS       (D),
      .SCAN_DIV     (SD),
      .BLANK_CYC    (BC),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .digits     (digits),
      .point      (point),
      .blink_mask (blink_mask),
      .blank_mask (blank_mask),
      .brightness (brightness),
      .ledCode    (ledCode),
      .an         (an),
      .scan_idx   (scan_idx),
      .frame_done (frame_done)
   );

   typedef struct {
      logic [15:0] dg;
      logic [3:0]  pt;
      logic [3:0]  bl;
      logic [3:0]  bk;
      logic [3:0]  br;
   } snap_t;

   typedef struct {
      logic [3:0] hx;
      logic       pt;
      logic [7:0] exp_led;
   } vec_t;

   snap_t      sh_q[$];
   logic [6:0] glyph_tab [16];
   vec_t       vecs [16];
   int         k;
   int         n_cmp = 0;
   int         n_bad = 0;

   // Model output after kk clock edges since reset release.
   function automatic void expect_out(input int kk, output logic [3:0] e_an,
                                      output logic [7:0] e_led, output logic [1:0] e_idx,
                                      output logic e_fd);
      int    s, c, i, f, on;
      logic  ph;
      snap_t sh;
      logic [3:0] one;
      e_an  = 4'hF;
      e_led = 8'hFF;
      e_idx = 2'd0;
      e_fd  = 1'b0;
      if (kk == 0) return;
      s  = kk - 1;
      c  = s % SD;
      i  = (s / SD) % D;
      f  = s / FR;
      sh = sh_q[f];
      e_idx = 2'(i);
      e_fd  = ((s % FR) == FR - 1);
      ph    = ((f / BF) % 2) == 1;
      on    = ((SD - BC) * (int'(sh.br) + 1)) / 16;
      if (c >= BC && c < BC + on && !sh.bk[i] && !(sh.bl[i] && ph)) begin
         one   = 4'b0001;
         e_an  = ~(one << i);
         e_led = {~sh.pt[i], glyph_tab[sh.dg[4*i +: 4]]};
      end
   endfunction

   task automatic check_now(input string nm);
      logic [3:0] e_an;
      logic [7:0] e_led;
      logic [1:0] e_idx;
      logic       e_fd;
      expect_out(k, e_an, e_led, e_idx, e_fd);
      n_cmp++;
      if (an !== e_an || ledCode !== e_led || scan_idx !== e_idx || frame_done !== e_fd) begin
         n_bad++;
         $display("FAIL %s k=%0d: got an=%h led=%h idx=%0d fd=%b, want an=%h led=%h idx=%0d fd=%b",
                  nm, k, an, ledCode, scan_idx, frame_done, e_an, e_led, e_idx, e_fd);
      end
   endtask

   task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s k=%0d: got %h, want %h", nm, k, act, exp);
      end
   endtask

   // One clock: check, optionally perturb inputs, snapshot at frame start, advance.
   task automatic step(input bit rnd, input string nm);
      snap_t sn;
      check_now(nm);
      if (rnd && $urandom_range(0, 19) == 0) begin
         digits     = 16'($urandom);
         point      = 4'($urandom);
         blink_mask = 4'($urandom);
         blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         brightness = 4'($urandom);
      end
      if (k % FR == 0) begin
         sn.dg = digits;
         sn.pt = point;
         sn.bl = blink_mask;
         sn.bk = blank_mask;
         sn.br = brightness;
         sh_q.push_back(sn);
      end
      @(posedge clk);
      k++;
      @(negedge clk);
   endtask

   task automatic run_to(input int t, input bit rnd, input string nm);
      while (k < t) step(rnd, nm);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      k = 0;
      sh_q.delete();
      check_now("reset");
      check_val("reset_idx", 32'(scan_idx), 32'd0);
      reset_n = 1'b1;
   endtask

   task automatic set_in(input logic [15:0] dg, input logic [3:0] pt, input logic [3:0] bl,
                         input logic [3:0] bk, input logic [3:0] br);
      digits     = dg;
      point      = pt;
      blink_mask = bl;
      blank_mask = bk;
      brightness = br;
   endtask

   initial begin
      glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      vecs = '{'{4'h0, 1'b0, 8'hC0}, '{4'h1, 1'b1, 8'h79}, '{4'h2, 1'b0, 8'hA4},
               '{4'h3, 1'b1, 8'h30}, '{4'h4, 1'b0, 8'h99}, '{4'h5, 1'b1, 8'h12},
               '{4'h6, 1'b0, 8'h82}, '{4'h7, 1'b1, 8'h78}, '{4'h8, 1'b0, 8'h80},
               '{4'h9, 1'b1, 8'h10}, '{4'hA, 1'b0, 8'h88}, '{4'hB, 1'b1, 8'h03},
               '{4'hC, 1'b0, 8'hC6}, '{4'hD, 1'b1, 8'h21}, '{4'hE, 1'b0, 8'h86},
               '{4'hF, 1'b1, 8'h0E}};
      reset_n = 1'b0;
      k       = 0;
      set_in(16'h3210, 4'h0, 4'h0, 4'h0, 4'hF);

      // Glyph and decimal point table, digit 0 at its first lit cycle
      for (int v = 0; v < 16; v++) begin
         set_in({4{vecs[v].hx}}, {4{vecs[v].pt}}, 4'h0, 4'h0, 4'hF);
         do_reset();
         run_to(5, 1'b0, "glyph_model");
         check_val("glyph_led", 32'(ledCode), 32'(vecs[v].exp_led));
         check_val("glyph_an", 32'(an), 32'hE);
      end

      // Full brightness scan, frame pulse and mid-frame input change
      set_in(16'h3210, 4'h0, 4'h0, 4'h0, 4'hF);
      do_reset();
      run_to(4, 1'b0, "full");
      check_val("blank_window_an", 32'(an), 32'hF);
      run_to(5, 1'b0, "full");
      check_val("d0_an", 32'(an), 32'hE);
      check_val("d0_led", 32'(ledCode), 32'hC0);
      run_to(40, 1'b0, "full");
      check_val("d0_last_lit", 32'(an), 32'hE);
      run_to(45, 1'b0, "full");
      check_val("d1_an", 32'(an), 32'hD);
      check_val("d1_led", 32'(ledCode), 32'hF9);
      run_to(50, 1'b0, "full");
      digits = 16'h7654;
      run_to(85, 1'b0, "full");
      check_val("midframe_old_led", 32'(ledCode), 32'hA4);
      run_to(159, 1'b0, "full");
      check_val("fd_before", 32'(frame_done), 32'd0);
      run_to(160, 1'b0, "full");
      check_val("fd_pulse", 32'(frame_done), 32'd1);
      check_val("fd_idx", 32'(scan_idx), 32'd3);
      run_to(161, 1'b0, "full");
      check_val("fd_after", 32'(frame_done), 32'd0);
      run_to(245, 1'b0, "full");
      check_val("newframe_led", 32'(ledCode), 32'h82);

      // Dimmest brightness: two lit cycles per slot
      set_in(16'h3210, 4'h0, 4'h0, 4'h0, 4'h0);
      do_reset();
      run_to(5, 1'b0, "dim");
      check_val("dim_on0", 32'(an), 32'hE);
      run_to(6, 1'b0, "dim");
      check_val("dim_on1", 32'(an), 32'hE);
      run_to(7, 1'b0, "dim");
      check_val("dim_off", 32'(an), 32'hF);

      // Blink on digit 1
      set_in(16'h3210, 4'h0, 4'b0010, 4'h0, 4'hF);
      do_reset();
      run_to(FR + 45, 1'b0, "blink");
      check_val("blink_f1_lit", 32'(an), 32'hD);
      run_to(2*FR + 45, 1'b0, "blink");
      check_val("blink_f2_dark", 32'(an), 32'hF);
      run_to(4*FR + 45, 1'b0, "blink");
      check_val("blink_f4_lit", 32'(an), 32'hD);

      // Forced blank on digit 3, point on digit 0
      set_in(16'h3210, 4'b0001, 4'h0, 4'b1000, 4'hF);
      do_reset();
      run_to(5, 1'b0, "blank");
      check_val("dp_led", 32'(ledCode), 32'h40);
      run_to(125, 1'b0, "blank");
      check_val("blank_d3_an", 32'(an), 32'hF);
      check_val("blank_d3_led", 32'(ledCode), 32'hFF);

      // Asynchronous reset in the middle of a lit slot
      set_in(16'h3210, 4'h0, 4'h0, 4'h0, 4'hF);
      do_reset();
      run_to(45, 1'b0, "async");
      check_val("async_pre_an", 32'(an), 32'hD);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("async_an", 32'(an), 32'hF);
      check_val("async_led", 32'(ledCode), 32'hFF);
      do_reset();
      run_to(5, 1'b0, "async_resume");
      check_val("resume_an", 32'(an), 32'hE);
      check_val("resume_idx", 32'(scan_idx), 32'd0);

      // Randomised inputs against the model
      set_in(16'($urandom), 4'($urandom), 4'($urandom), 4'h0, 4'($urandom));
      do_reset();
      run_to(30*FR, 1'b1, "random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_scan_multi.md
Name: led_scan_multi

Overview:
- Parametrised multiplexed 7-segment scanner driving DIGITS common-anode digits from one shared segment bus.
- Adds features the 8-digit fixed scanner lacks: per-slot ghost blanking, 16-level brightness PWM, per-digit blink and force-blank, and frame-coherent input capture.
- Sits between clock/alarm display logic and the board's segment/anode pins.

Parameters:
- DIGITS, 8, number of digits scanned (2..16).
- SCAN_DIV, 50000, clk cycles per digit slot (must be > BLANK_CYC+16).
- BLANK_CYC, 500, cycles at the start of each slot with all anodes off (ghost suppression).
- BLINK_FRAMES, 128, frames per blink half-period (≥1).
- IDX_W, $clog2(DIGITS), width of the scan index.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- digits  in  4*DIGITS  hex code per digit; digit k = digits[4k+3:4k]
- point  in  DIGITS  decimal point per digit, 1 = lit
- blink_mask  in  DIGITS  1 = digit blinks
- blank_mask  in  DIGITS  1 = digit forced dark
- brightness  in  4  duty level, 0 = dimmest lit, 15 = full
- ledCode  out  8  segments, active low; [7] = dp, [6:0] = gfedcba
- an  out  DIGITS  anode selects, active low, at most one bit low
- scan_idx  out  IDX_W  digit currently in its slot
- frame_done  out  1  one-cycle pulse at end of last digit slot

Behaviour:
- Reset (asynchronous, reset_n=0): an all 1, ledCode=8'hFF, scan_idx=0, frame_done=0, slot counter=0, blink phase=0, shadow registers (digits/point/masks/brightness)=0. Outputs stay at these values until the first slot's active window.
- Slot counter runs 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and scan_idx advances; DIGITS-1 wraps to 0.
- frame_done=1 for exactly the cycle in which the counter wraps with scan_idx=DIGITS-1.
- Frame capture: on the cycle after frame_done, and on the first cycle after reset release, digits, point, blink_mask, blank_mask and brightness are copied into shadows. Mid-frame input changes have no visible effect until the next frame.
- Blink phase toggles after every BLINK_FRAMES completed frames.
- Active window: ON_CYC = ((SCAN_DIV-BLANK_CYC)*(brightness_shadow+1))>>4. Digit i is lit while BLANK_CYC ≤ slot_cnt < BLANK_CYC+ON_CYC. ON_CYC is precomputed at frame capture; no multiplier in the per-cycle path.
- A digit is suppressed (dark for its whole slot) if blank_mask[i]=1, or if blink_mask[i]=1 and blink phase=1.
- When lit: an = ~(1<<scan_idx), ledCode[6:0] = glyph(digit), ledCode[7] = ~point[i].
- When not lit: an all 1, ledCode = 8'hFF.
- Glyph table, [6:0] hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Latency: an, ledCode, scan_idx and frame_done are all registered, one cycle after the counter state that produces them. an and ledCode always change on the same edge; there is no glitch or overlap between digits.
- Reset asserted mid-frame forces reset values immediately (asynchronous). Scanning restarts at digit 0, slot count 0, with new shadows captured.

Test Plan (DIGITS=4, SCAN_DIV=40, BLANK_CYC=4, BLINK_FRAMES=2):
- Reset, then digits=16'h3210, point=0, brightness=15 -> per slot: 4 cycles an=4'hF, then 36 cycles an=E/D/B/7 with ledCode=C0/F9/A4/B0; frame_done pulses every 160 cycles.
- brightness=0 -> ON_CYC=(36*1)>>4=2; each digit lit exactly 2 cycles after blanking, dark for the remaining 34.
- blink_mask=4'b0010 -> digit 1 lit in frames 0-1, dark in frames 2-3, lit in 4-5; other digits unaffected.
- blank_mask=4'b1000, point=4'b0001 -> digit 3 never lit; digit 0 ledCode=8'h40.
- Change digits mid-frame (at cycle 50) -> no output change until the slot after the next frame_done.
- Assert reset_n=0 asynchronously mid-slot -> an=4'hF, ledCode=FF the same instant; after release, scanning resumes from digit 0.
